// File: rtl/ledr_effect_driver.sv
// LED effect driver: sits between the red-LED PIO and the LEDR pins and
// applies global enable, PWM dimming and per-LED blinking configured by
// software through a small Avalon-MM register bank.
module ledr_effect_driver #(
  parameter int WIDTH     = 18,
  parameter int PWM_BITS  = 8,
  parameter int PER_BITS  = 24,
  parameter int PER_RESET = 12500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pattern_in,
  output logic [WIDTH-1:0] led_out,
  output logic             blink_phase
);

  localparam logic [PER_BITS-1:0] PER_ONE = PER_BITS'(1);
  localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

  logic                r_enable;
  logic                r_blinkEn;
  logic [PWM_BITS-1:0] r_bright;
  logic [WIDTH-1:0]    r_mask;
  logic [PER_BITS-1:0] r_period;
  logic [WIDTH-1:0]    r_patternQ;
  logic [PWM_BITS-1:0] r_pwmCnt;
  logic [PER_BITS-1:0] r_blinkCnt;
  logic                r_blinkPhase;

  logic w_wr;
  logic w_blinkRestart;
  logic w_blinkActive;
  logic w_pwmOn;
  logic w_unusedBits;

  assign w_wr           = chipselect & ~write_n;
  assign w_blinkRestart = w_wr & ((address == 2'd0) | (address == 2'd3));
  assign w_blinkActive  = r_blinkEn & (r_period != '0);
  assign w_pwmOn        = (r_bright == '1) ? 1'b1 : (r_pwmCnt < r_bright);
  assign blink_phase    = r_blinkPhase;
  assign w_unusedBits   = &{1'b0, writedata[31:PER_BITS]};

  // Software-visible configuration registers, written on a selected write strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable  <= 1'b1;
      r_blinkEn <= 1'b0;
      r_bright  <= '1;
      r_mask    <= '0;
      r_period  <= PER_BITS'(PER_RESET);
    end else if (w_wr) begin
      case (address)
        2'd0: {r_blinkEn, r_enable} <= writedata[1:0];
        2'd1: r_bright <= writedata[PWM_BITS-1:0];
        2'd2: r_mask   <= writedata[WIDTH-1:0];
        2'd3: r_period <= writedata[PER_BITS-1:0];
        default: ;
      endcase
    end
  end

  // Register the incoming PIO pattern so the output path starts from a clean flop
  always_ff @(posedge clk) begin
    if (reset) r_patternQ <= '0;
    else       r_patternQ <= pattern_in;
  end

  // Free-running PWM frame counter, wraps naturally at its width
  always_ff @(posedge clk) begin
    if (reset) r_pwmCnt <= '0;
    else       r_pwmCnt <= r_pwmCnt + PWM_ONE;
  end

  // Blink half-period timer; a CTRL/PERIOD write restarts it and beats a terminal count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b1;
    end else if (w_blinkRestart || !w_blinkActive) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b1;
    end else if (r_blinkCnt == r_period - PER_ONE) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= ~r_blinkPhase;
    end else begin
      r_blinkCnt   <= r_blinkCnt + PER_ONE;
    end
  end

  // Output flop combining enable, pattern, PWM gate and blink gate per LED
  always_ff @(posedge clk) begin
    if (reset) led_out <= '0;
    else       led_out <= {WIDTH{r_enable & w_pwmOn}} & r_patternQ &
                          (~r_mask | {WIDTH{~r_blinkEn | r_blinkPhase}});
  end

  // Combinational register readback, zero-extended with no side effects
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = {30'd0, r_blinkEn, r_enable};
      2'd1: readdata = 32'(r_bright);
      2'd2: readdata = 32'(r_mask);
      2'd3: readdata = 32'(r_period);
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ledr_effect_driver.sv
// Self-checking bench for ledr_effect_driver: scenario tasks plus a
// randomized run checked against a timing-arithmetic reference model.
module tb_ledr_effect_driver;

  localparam int PER_RESET = 12500000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [17:0] pattern_in;
  logic [17:0] led_out;
  logic        blink_phase;

  int passCount  = 0;
  int checkCount = 0;

  // Model bookkeeping: edge numbering, last reset edge, last blink restart edge
  int   edgeCount = 0;
  int   lastResetEdge = 0;
  int   lastRestartEdge = 0;
  bit   resetAtEdge = 1'b0;
  logic [17:0] p1 = '0;
  logic [17:0] p2 = '0;

  // Shadow of the software-visible registers
  bit          mEnable;
  bit          mBlinkEn;
  int          mBright;
  logic [17:0] mMask;
  int          mPeriod;

  ledr_effect_driver dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .pattern_in  (pattern_in),
    .led_out     (led_out),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  // Record edge-level events the model needs: pattern history, resets, blink restarts
  always @(posedge clk) begin
    edgeCount++;
    p2 = p1;
    p1 = pattern_in;
    resetAtEdge = reset;
    if (reset) begin
      lastResetEdge   = edgeCount;
      lastRestartEdge = edgeCount;
    end else if (chipselect && !write_n && (address == 2'd0 || address == 2'd3)) begin
      lastRestartEdge = edgeCount;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void resetShadow();
    mEnable  = 1'b1;
    mBlinkEn = 1'b0;
    mBright  = 255;
    mMask    = '0;
    mPeriod  = PER_RESET;
  endfunction

  // Blink phase after edge e: toggles once per completed half-period since restart
  function automatic bit phaseAfter(int e);
    if (e <= lastResetEdge) return 1'b1;
    if (!mBlinkEn || mPeriod == 0) return 1'b1;
    return (((e - lastRestartEdge) / mPeriod) % 2) == 0;
  endfunction

  // Expected led_out after the most recent edge
  function automatic logic [17:0] expLed();
    int e;
    int pwmVal;
    bit pwmOn;
    logic [17:0] g;
    e = edgeCount;
    if (resetAtEdge || (e - 1) <= lastResetEdge) return '0;
    pwmVal = (e - 1 - lastResetEdge) % 256;
    pwmOn  = (mBright == 255) ? 1'b1 : (pwmVal < mBright);
    if (!mEnable || !pwmOn) return '0;
    g = (mBlinkEn && !phaseAfter(e - 1)) ? ~mMask : 18'h3FFFF;
    return p2 & g;
  endfunction

  function automatic logic [31:0] expRead(logic [1:0] a);
    case (a)
      2'd0: return {30'd0, mBlinkEn, mEnable};
      2'd1: return 32'(mBright);
      2'd2: return {14'd0, mMask};
      default: return 32'(mPeriod);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doWrite(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    case (a)
      2'd0: {mBlinkEn, mEnable} = d[1:0];
      2'd1: mBright = int'(d[7:0]);
      2'd2: mMask = d[17:0];
      default: mPeriod = int'(d[23:0]);
    endcase
  endtask

  task automatic test_reset();
    logic [31:0] want [4];
    want[0] = 32'h1;
    want[1] = 32'hFF;
    want[2] = 32'h0;
    want[3] = PER_RESET;
    reset = 1'b1;
    pattern_in = 18'h3FFFF;
    resetShadow();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCount++;
      if (led_out !== 18'h0) $display("[TB] FAIL reset_led: got %h want %h", led_out, 18'h0);
      else passCount++;
    end
    checkCount++;
    if (blink_phase !== 1'b1) $display("[TB] FAIL reset_phase: got %b want 1", blink_phase);
    else passCount++;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      checkCount++;
      if (readdata !== want[a]) $display("[TB] FAIL reset_read%0d: got %h want %h", a, readdata, want[a]);
      else passCount++;
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checkCount++;
    if (led_out !== 18'h0) $display("[TB] FAIL release_1clk: got %h want %h", led_out, 18'h0);
    else passCount++;
    tick();
    checkCount++;
    if (led_out !== 18'h3FFFF) $display("[TB] FAIL release_2clk: got %h want %h", led_out, 18'h3FFFF);
    else passCount++;
  endtask

  task automatic test_latency();
    pattern_in = 18'h0;
    repeat (3) tick();
    pattern_in = 18'h2AAAA;
    tick();
    checkCount++;
    if (led_out !== 18'h0) $display("[TB] FAIL latency_early: got %h want %h", led_out, 18'h0);
    else passCount++;
    tick();
    checkCount++;
    if (led_out !== 18'h2AAAA) $display("[TB] FAIL latency_due: got %h want %h", led_out, 18'h2AAAA);
    else passCount++;
  endtask

  task automatic test_pwm();
    int highs;
    int brights [3];
    int wants [3];
    brights[0] = 8'h40; wants[0] = 64;
    brights[1] = 8'h00; wants[1] = 0;
    brights[2] = 8'hFF; wants[2] = 256;
    pattern_in = 18'h1;
    for (int b = 0; b < 3; b++) begin
      doWrite(2'd1, 32'(brights[b]));
      tick();
      highs = 0;
      for (int i = 0; i < 256; i++) begin
        tick();
        if (led_out[0]) highs++;
        checkCount++;
        if (led_out !== expLed()) $display("[TB] FAIL pwm_cycle: got %h want %h", led_out, expLed());
        else passCount++;
      end
      checkCount++;
      if (highs !== wants[b]) $display("[TB] FAIL pwm_duty_%0d: got %0d want %0d", brights[b], highs, wants[b]);
      else passCount++;
    end
  endtask

  task automatic test_blink();
    pattern_in = 18'h3;
    doWrite(2'd3, 32'd4);
    doWrite(2'd2, 32'h1);
    doWrite(2'd0, 32'h3);
    for (int i = 0; i < 24; i++) begin
      tick();
      checkCount++;
      if (led_out !== expLed()) $display("[TB] FAIL blink_led: got %h want %h", led_out, expLed());
      else passCount++;
      checkCount++;
      if (blink_phase !== phaseAfter(edgeCount)) $display("[TB] FAIL blink_phase: got %b want %b", blink_phase, phaseAfter(edgeCount));
      else passCount++;
      checkCount++;
      if (i > 0 && led_out[1] !== 1'b1) $display("[TB] FAIL blink_steady_bit1: got %b want 1", led_out[1]);
      else passCount++;
    end
    doWrite(2'd3, 32'd0);
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      checkCount++;
      if (led_out !== 18'h3) $display("[TB] FAIL blink_period0: got %h want %h", led_out, 18'h3);
      else passCount++;
    end
  endtask

  task automatic test_collision();
    logic [1:0] wantPh [5];
    doWrite(2'd3, 32'd4);
    doWrite(2'd0, 32'h3);
    for (int k = 0; k < 8 && (edgeCount - lastRestartEdge) != 3; k++) tick();
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd3;
    writedata  = 32'd4;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    checkCount++;
    if (blink_phase !== 1'b1) $display("[TB] FAIL collision_phase: got %b want 1", blink_phase);
    else passCount++;
    wantPh[1] = 1; wantPh[2] = 1; wantPh[3] = 1; wantPh[4] = 0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      checkCount++;
      if (blink_phase !== wantPh[j][0]) $display("[TB] FAIL collision_restart_%0d: got %b want %b", j, blink_phase, wantPh[j][0]);
      else passCount++;
    end
  endtask

  task automatic test_disable();
    pattern_in = 18'h3FFFF;
    doWrite(2'd1, 32'hFF);
    doWrite(2'd2, 32'h3FFFF);
    doWrite(2'd0, 32'h1);
    tick();
    checkCount++;
    if (led_out !== 18'h3FFFF) $display("[TB] FAIL disable_before: got %h want %h", led_out, 18'h3FFFF);
    else passCount++;
    doWrite(2'd0, 32'h0);
    checkCount++;
    if (led_out !== 18'h3FFFF) $display("[TB] FAIL disable_1clk: got %h want %h", led_out, 18'h3FFFF);
    else passCount++;
    for (int i = 0; i < 6; i++) begin
      pattern_in = 18'($urandom);
      tick();
      checkCount++;
      if (led_out !== 18'h0) $display("[TB] FAIL disable_off: got %h want %h", led_out, 18'h0);
      else passCount++;
    end
  endtask

  task automatic test_random();
    logic [1:0]  a;
    logic [31:0] d;
    doWrite(2'd0, 32'h1);
    for (int i = 0; i < 400; i++) begin
      pattern_in = 18'($urandom);
      if (i == 200) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        resetShadow();
        checkCount++;
        if (led_out !== 18'h0 || blink_phase !== 1'b1)
          $display("[TB] FAIL midreset: got led %h phase %b want 0 and 1", led_out, blink_phase);
        else passCount++;
      end else if (i % 20 == 0) begin
        a = 2'($urandom_range(0, 3));
        d = $urandom;
        if (a == 2'd3) d[23:0] = 24'($urandom_range(0, 7));
        if (a == 2'd0) d[1:0] = 2'($urandom_range(1, 3));
        doWrite(a, d);
        address = a;
        #1;
        checkCount++;
        if (readdata !== expRead(a)) $display("[TB] FAIL rand_read%0d: got %h want %h", a, readdata, expRead(a));
        else passCount++;
      end else begin
        tick();
        checkCount++;
        if (led_out !== expLed()) $display("[TB] FAIL rand_led: got %h want %h", led_out, expLed());
        else passCount++;
        checkCount++;
        if (blink_phase !== phaseAfter(edgeCount)) $display("[TB] FAIL rand_phase: got %b want %b", blink_phase, phaseAfter(edgeCount));
        else passCount++;
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    pattern_in = '0;
    resetShadow();
    test_reset();
    test_latency();
    test_pwm();
    test_blink();
    test_collision();
    test_disable();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
